// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
// Segment codes are active-low; bit positions match the keypad scanner's code table.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam int SEG_DP = 7;
  localparam int SEG_A  = 6;
  localparam int SEG_B  = 5;
  localparam int SEG_C  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 2;
  localparam int SEG_F  = 1;
  localparam int SEG_G  = 0;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_t;

  // One-cold common-anode enable for the given digit index.
  function automatic logic [3:0] an_select(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/seg_pwm_gate.sv
// 4-bit brightness PWM counter; o_on_nxt says whether the count after this edge is below i_bright.
// Latency: o_on_nxt is combinational from the next count so the caller can register it in step.
module seg_pwm_gate (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [3:0] i_bright,
  output logic       o_on_nxt
);

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = 4'd0;
    end else if (i_inc) begin
      w_cnt_nxt = r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_on_nxt = (w_cnt_nxt < i_bright);

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexes four active-low digit codes onto one segment bus with blanking, PWM dimming and per-frame capture.
// All outputs registered (one cycle after the controlling edge); no backpressure, the display free-runs while en=1.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bright,
  input  logic [7:0] dig1,
  input  logic [7:0] dig2,
  input  logic [7:0] dig3,
  input  logic [7:0] dig4,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);

  if (CLK_DIV < BLANK_CYCLES + 16) begin : g_bad_timing
    $fatal(1, "seg_display_mux: CLK_DIV must be at least BLANK_CYCLES + 16");
  end

  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [1:0]        r_digit;
  logic [7:0]        r_shadow [4];
  logic [7:0]        r_seg;
  logic [3:0]        r_an;
  logic              r_frame_tick;

  logic w_show_stay;
  logic w_pwm_on_nxt;

  // The PWM phase restarts at every SHOW entry and only runs while SHOW continues.
  assign w_show_stay = en && (r_state == SHOW) && (r_slot != SLOT_LAST);

  seg_pwm_gate u_pwm (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_show_stay),
    .i_inc    (w_show_stay),
    .i_bright (bright),
    .o_on_nxt (w_pwm_on_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_slot       <= '0;
      r_digit      <= 2'd0;
      r_seg        <= SEG_BLANK;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= SEG_BLANK;
    end else if (!en) begin
      r_state      <= IDLE;
      r_slot       <= '0;
      r_digit      <= 2'd0;
      r_seg        <= SEG_BLANK;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state      <= BLANK;
          r_slot       <= '0;
          r_digit      <= 2'd0;
          r_shadow[0]  <= dig1;
          r_shadow[1]  <= dig2;
          r_shadow[2]  <= dig3;
          r_shadow[3]  <= dig4;
          r_frame_tick <= 1'b1;
          r_an         <= AN_OFF;
          r_seg        <= SEG_BLANK;
        end
        BLANK: begin
          r_slot <= r_slot + 1'b1;
          if (r_slot == BLANK_LAST) begin
            r_state <= SHOW;
            r_an    <= w_pwm_on_nxt ? an_select(r_digit) : AN_OFF;
            r_seg   <= r_shadow[r_digit];
          end else begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
          end
        end
        SHOW: begin
          if (r_slot == SLOT_LAST) begin
            r_state <= BLANK;
            r_slot  <= '0;
            r_digit <= r_digit + 1'b1;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
            // Wrapping past the leftmost digit starts a new frame: capture all four codes together.
            if (r_digit == 2'd3) begin
              r_shadow[0]  <= dig1;
              r_shadow[1]  <= dig2;
              r_shadow[2]  <= dig3;
              r_shadow[3]  <= dig4;
              r_frame_tick <= 1'b1;
            end
          end else begin
            r_slot <= r_slot + 1'b1;
            r_an   <= w_pwm_on_nxt ? an_select(r_digit) : AN_OFF;
            r_seg  <= r_shadow[r_digit];
          end
        end
        default: begin
          r_state <= IDLE;
          r_an    <= AN_OFF;
          r_seg   <= SEG_BLANK;
        end
      endcase
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with CLK_DIV=40, BLANK_CYCLES=4 (frame = 160 cycles).
// Frame position p tracks where the display should be; p=-1 means dark/idle.
module tb_seg_display_mux;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] bright;
  logic [7:0] dig1, dig2, dig3, dig4;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int n_checks;
  int n_fail;
  int p;
  logic [3:0][7:0] exp_sh;

  seg_display_mux #(.CLK_DIV(40), .BLANK_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bright     (bright),
    .dig1       (dig1),
    .dig2       (dig2),
    .dig3       (dig3),
    .dig4       (dig4),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] m_an(input int pp, input logic [3:0] b);
    int slot;
    int d;
    if (pp < 0) return 4'hF;
    slot = pp % 40;
    d    = pp / 40;
    if (slot < 4) return 4'hF;
    if (((slot - 4) % 16) < int'(b)) return ~(4'b0001 << d);
    return 4'hF;
  endfunction

  function automatic logic [7:0] m_seg(input int pp, input logic [3:0][7:0] sh);
    if (pp < 0) return 8'hFF;
    if ((pp % 40) < 4) return 8'hFF;
    return sh[pp / 40];
  endfunction

  // Advance one clock; inputs are only changed at negedges, so they are stable at the edge.
  task automatic step();
    @(posedge clk);
    if (!en) begin
      p = -1;
    end else begin
      p = (p + 1) % 160;
      if (p == 0) exp_sh = {dig4, dig3, dig2, dig1};
    end
    @(negedge clk);
  endtask

  task automatic goto_pos(input int target);
    for (int i = 0; i < 400; i++) begin
      if (p == target) break;
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dig1 = 8'h81; dig2 = 8'h80; dig3 = 8'hA4; dig4 = 8'h92;
    bright = 4'd15;
    en = 1'b1;
    repeat (10) step();
    n_checks++;
    if (an !== m_an(p, bright)) begin
      n_fail++; $display("FAIL reset_prerun_an got %b exp %b", an, m_an(p, bright));
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_async_an got %b exp 1111", an); end
    n_checks++;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_async_seg got %h exp ff", seg); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_async_tick got %b exp 0", frame_tick); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dig1 = ~dig1; dig3 = ~dig3; en = ~en;
      @(negedge clk);
      n_checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold an=%b seg=%h tick=%b exp 1111/ff/0", an, seg, frame_tick);
      end
    end
    en = 1'b0;
    dig1 = 8'h81; dig3 = 8'hA4;
    rst = 1'b0;
    p = -1;
    step();
    n_checks++;
    if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle an=%b seg=%h tick=%b exp 1111/ff/0", an, seg, frame_tick);
    end
  endtask

  task automatic test_scan_order();
    int ticks;
    ticks = 0;
    bright = 4'd15;
    en = 1'b1;
    for (int k = 0; k < 320; k++) begin
      step();
      if (frame_tick === 1'b1) ticks++;
      n_checks++;
      if (an !== m_an(p, bright) || seg !== m_seg(p, exp_sh) || frame_tick !== (p == 0)) begin
        n_fail++;
        $display("FAIL scan p=%0d an=%b seg=%h tick=%b exp %b/%h/%b", p, an, seg, frame_tick,
                 m_an(p, bright), m_seg(p, exp_sh), (p == 0));
      end
    end
    n_checks++;
    if (ticks !== 2) begin n_fail++; $display("FAIL scan_tick_count got %0d exp 2", ticks); end
  endtask

  task automatic test_tearing();
    goto_pos(44);
    dig2 = 8'hCF;
    for (int k = 0; k < 200; k++) begin
      step();
      n_checks++;
      if (an !== m_an(p, bright) || seg !== m_seg(p, exp_sh) || frame_tick !== (p == 0)) begin
        n_fail++;
        $display("FAIL tearing p=%0d an=%b seg=%h tick=%b exp %b/%h/%b", p, an, seg, frame_tick,
                 m_an(p, bright), m_seg(p, exp_sh), (p == 0));
      end
    end
  endtask

  task automatic test_dimming();
    int on_cnt [4];
    int dark_on;
    for (int d = 0; d < 4; d++) on_cnt[d] = 0;
    goto_pos(159);
    bright = 4'd4;
    for (int k = 0; k < 160; k++) begin
      step();
      if (an !== 4'hF) on_cnt[p / 40]++;
      n_checks++;
      if (an !== m_an(p, bright) || seg !== m_seg(p, exp_sh)) begin
        n_fail++;
        $display("FAIL dim4 p=%0d an=%b seg=%h exp %b/%h", p, an, seg, m_an(p, bright), m_seg(p, exp_sh));
      end
    end
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (on_cnt[d] !== 12) begin
        n_fail++; $display("FAIL dim4_window digit=%0d on=%0d exp 12", d, on_cnt[d]);
      end
    end
    bright = 4'd0;
    dark_on = 0;
    for (int k = 0; k < 160; k++) begin
      step();
      if (an !== 4'hF) dark_on++;
    end
    n_checks++;
    if (dark_on !== 0) begin n_fail++; $display("FAIL dim0_frame on_cycles=%0d exp 0", dark_on); end
    bright = 4'd15;
  endtask

  task automatic test_enable_drop();
    goto_pos(50);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL en_drop k=%0d an=%b seg=%h tick=%b exp 1111/ff/0", k, an, seg, frame_tick);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      n_checks++;
      if (an !== m_an(p, bright) || seg !== m_seg(p, exp_sh) || frame_tick !== (p == 0)) begin
        n_fail++;
        $display("FAIL en_resume p=%0d an=%b seg=%h tick=%b exp %b/%h/%b", p, an, seg, frame_tick,
                 m_an(p, bright), m_seg(p, exp_sh), (p == 0));
      end
    end
  endtask

  task automatic test_simultaneous();
    goto_pos(159);
    en = 1'b0;
    dig1 = 8'hF9; dig2 = 8'hC0; dig3 = 8'h99; dig4 = 8'h82;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_en_drop k=%0d an=%b seg=%h tick=%b exp 1111/ff/0", k, an, seg, frame_tick);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 45; k++) begin
      step();
      n_checks++;
      if (an !== m_an(p, bright) || seg !== m_seg(p, exp_sh) || frame_tick !== (p == 0)) begin
        n_fail++;
        $display("FAIL wrap_resume p=%0d an=%b seg=%h tick=%b exp %b/%h/%b", p, an, seg, frame_tick,
                 m_an(p, bright), m_seg(p, exp_sh), (p == 0));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    p        = -1;
    exp_sh   = {4{8'hFF}};
    rst      = 1'b1;
    en       = 1'b0;
    bright   = 4'd0;
    dig1 = 8'hFF; dig2 = 8'hFF; dig3 = 8'hFF; dig4 = 8'hFF;
    test_reset();
    test_scan_order();
    test_tearing();
    test_dimming();
    test_enable_drop();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
